// File: rtl/vfpu_op_issue_if.sv
// Bus bundle between the VFPU issue stage and its environment.
// slave  : the issue stage itself (takes operand triples and DUT results,
//          drives the op port, the scoreboard port and the error flags).
// master : whoever drives operands and DUT results into the issue stage.
interface vfpu_op_issue_if;
    // upstream operand triple handshake
    logic        in_vld;
    logic        in_rdy;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [31:0] in_c;
    // issue strobe to the DUT wrapper (no backpressure)
    logic        op_vld;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [31:0] operand_c;
    // result strobe from the DUT wrapper
    logic        res_rdy;
    logic [31:0] res;
    // completed operation to the scoreboard
    logic        sb_vld;
    logic [31:0] sb_a;
    logic [31:0] sb_b;
    logic [31:0] sb_c;
    logic [31:0] sb_res;
    // sticky error flags
    logic        err_unexp;
    logic        err_tmo;

    modport slave (
        input  in_vld, in_a, in_b, in_c, res_rdy, res,
        output in_rdy, op_vld, operand_a, operand_b, operand_c,
               sb_vld, sb_a, sb_b, sb_c, sb_res, err_unexp, err_tmo
    );

    modport master (
        output in_vld, in_a, in_b, in_c, res_rdy, res,
        input  in_rdy, op_vld, operand_a, operand_b, operand_c,
               sb_vld, sb_a, sb_b, sb_c, sb_res, err_unexp, err_tmo
    );
endinterface

// File: rtl/vfpu_op_issue.sv
// VFPU issue stage: accepts operand triples, issues them to the DUT wrapper,
// remembers them in an order FIFO and pairs each returned result with the
// operands that produced it for the scoreboard. Flags unexpected and overdue
// results and then locks up in ERR until reset.
// Optional feature: define VFPU_ISSUE_STATS_EN to add the issue_cnt/cmpl_cnt
// statistics outputs.
module vfpu_op_issue #(
    parameter int MAX_OUT = 8,   // in-flight limit and FIFO depth, power of two
    parameter int TIMEOUT = 64   // max cycles without a pop while ops outstanding
) (
    input  logic              clk,
    input  logic              rst,
    vfpu_op_issue_if.slave    bus
`ifdef VFPU_ISSUE_STATS_EN
    ,
    output logic [31:0]       issue_cnt,
    output logic [31:0]       cmpl_cnt
`endif
);

    localparam int CNT_W = $clog2(MAX_OUT + 1);
    localparam int PTR_W = $clog2(MAX_OUT);
    localparam int AGE_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(TIMEOUT);
    localparam logic [AGE_W-1:0] AGE_ONE = AGE_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        FULL = 2'd2,
        ERR  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
    logic [AGE_W-1:0]  age_q, age_d;
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;

    // order FIFO entry = {a, b, c}
    logic [95:0]       fifo_mem [MAX_OUT];

    logic              op_vld_q;
    logic [31:0]       operand_a_q, operand_b_q, operand_c_q;
    logic              sb_vld_q;
    logic [31:0]       sb_a_q, sb_b_q, sb_c_q, sb_res_q;
    logic              err_unexp_q, err_tmo_q;

    logic              in_err;
    logic              accept;
    logic              pop;
    logic              unexp;
    logic              tmo;

    assign in_err = (state_q == ERR);

    // Ready depends only on registered state (and reset), so a pop while
    // FULL only reopens the input on the following cycle.
    assign bus.in_rdy = !rst && !in_err && (out_cnt_q < CNT_MAX);

    assign accept = bus.in_vld && bus.in_rdy;
    assign pop    = !in_err && bus.res_rdy && (out_cnt_q != '0);
    assign unexp  = !in_err && bus.res_rdy && (out_cnt_q == '0);

    // Occupancy and age bookkeeping. Age is evaluated against the
    // post-update occupancy so that it counts every cycle an op has been
    // visible as outstanding, starting with the cycle after its accept.
    always_comb begin
        out_cnt_d = out_cnt_q;
        age_d     = age_q;
        unique case ({accept, pop})
            2'b10:   out_cnt_d = out_cnt_q + CNT_ONE;
            2'b01:   out_cnt_d = out_cnt_q - CNT_ONE;
            default: out_cnt_d = out_cnt_q;
        endcase
        if (!in_err) begin
            if (pop || (out_cnt_d == '0)) begin
                age_d = '0;
            end else if (age_q != AGE_MAX) begin
                age_d = age_q + AGE_ONE;
            end
        end
        tmo = !in_err && (age_d == AGE_MAX);
    end

    // Next-state: ERR is absorbing; otherwise state tracks next occupancy.
    always_comb begin
        state_d = state_q;
        if (in_err || unexp || tmo) begin
            state_d = ERR;
        end else if (out_cnt_d == '0) begin
            state_d = IDLE;
        end else if (out_cnt_d == CNT_MAX) begin
            state_d = FULL;
        end else begin
            state_d = BUSY;
        end
    end

    // Order FIFO storage: written in the handshake cycle, no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            fifo_mem[wr_ptr_q] <= {bus.in_a, bus.in_b, bus.in_c};
        end
    end

    // Control state, issue port, scoreboard port (registered FIFO read) and
    // sticky error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            out_cnt_q   <= '0;
            age_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            op_vld_q    <= 1'b0;
            operand_a_q <= '0;
            operand_b_q <= '0;
            operand_c_q <= '0;
            sb_vld_q    <= 1'b0;
            sb_a_q      <= '0;
            sb_b_q      <= '0;
            sb_c_q      <= '0;
            sb_res_q    <= '0;
            err_unexp_q <= 1'b0;
            err_tmo_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            out_cnt_q <= out_cnt_d;
            age_q     <= age_d;
            op_vld_q  <= accept;
            sb_vld_q  <= pop;
            if (accept) begin
                operand_a_q <= bus.in_a;
                operand_b_q <= bus.in_b;
                operand_c_q <= bus.in_c;
                wr_ptr_q    <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                sb_a_q   <= fifo_mem[rd_ptr_q][95:64];
                sb_b_q   <= fifo_mem[rd_ptr_q][63:32];
                sb_c_q   <= fifo_mem[rd_ptr_q][31:0];
                sb_res_q <= bus.res;
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            if (unexp) begin
                err_unexp_q <= 1'b1;
            end
            if (tmo) begin
                err_tmo_q <= 1'b1;
            end
        end
    end

`ifdef VFPU_ISSUE_STATS_EN
    logic [31:0] issue_cnt_q, cmpl_cnt_q;

    // Statistics counters move with the op_vld / sb_vld strobes they count.
    always_ff @(posedge clk) begin
        if (rst) begin
            issue_cnt_q <= '0;
            cmpl_cnt_q  <= '0;
        end else begin
            if (accept) begin
                issue_cnt_q <= issue_cnt_q + 32'd1;
            end
            if (pop) begin
                cmpl_cnt_q <= cmpl_cnt_q + 32'd1;
            end
        end
    end

    assign issue_cnt = issue_cnt_q;
    assign cmpl_cnt  = cmpl_cnt_q;
`endif

    assign bus.op_vld    = op_vld_q;
    assign bus.operand_a = operand_a_q;
    assign bus.operand_b = operand_b_q;
    assign bus.operand_c = operand_c_q;
    assign bus.sb_vld    = sb_vld_q;
    assign bus.sb_a      = sb_a_q;
    assign bus.sb_b      = sb_b_q;
    assign bus.sb_c      = sb_c_q;
    assign bus.sb_res    = sb_res_q;
    assign bus.err_unexp = err_unexp_q;
    assign bus.err_tmo   = err_tmo_q;

endmodule

// File: tb/tb_vfpu_op_issue.sv
// Self-checking bench for vfpu_op_issue (MAX_OUT=8, TIMEOUT=64).
// Expected issues and completions are queued when stimulus is driven and
// compared by a negedge monitor when the DUT produces them.
`timescale 1ns/1ps
module tb_vfpu_op_issue;

    logic clk;
    logic rst;

    vfpu_op_issue_if bus ();

`ifdef VFPU_ISSUE_STATS_EN
    logic [31:0] issue_cnt;
    logic [31:0] cmpl_cnt;
`endif

    vfpu_op_issue #(
        .MAX_OUT (8),
        .TIMEOUT (64)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
`ifdef VFPU_ISSUE_STATS_EN
        ,
        .issue_cnt (issue_cnt),
        .cmpl_cnt  (cmpl_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // expectation queues
    logic [95:0]  exp_op_q [$];   // {a,b,c} expected on op_vld
    logic [127:0] exp_sb_q [$];   // {a,b,c,res} expected on sb_vld
    logic [95:0]  mdl_q    [$];   // model of outstanding ops
    bit           mdl_err;
    int           n_op_seen = 0;
    int           n_sb_seen = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle of stimulus; queues whatever the DUT should produce for it.
    task automatic drive(input bit v, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input bit rr, input logic [31:0] r);
        bit          exp_rdy;
        int          pre;
        logic [95:0] t;
        exp_rdy = !mdl_err && (mdl_q.size() < 8);
        pre     = mdl_q.size();
        bus.in_vld  = v;
        bus.in_a    = a;
        bus.in_b    = b;
        bus.in_c    = c;
        bus.res_rdy = rr;
        bus.res     = r;
        check("in_rdy", 32'(bus.in_rdy), 32'(exp_rdy));
        if (rr && !mdl_err) begin
            if (pre > 0) begin
                t = mdl_q.pop_front();
                exp_sb_q.push_back({t, r});
            end else begin
                mdl_err = 1'b1;
            end
        end
        if (v && exp_rdy) begin
            exp_op_q.push_back({a, b, c});
            mdl_q.push_back({a, b, c});
        end
        tick();
        bus.in_vld  = 1'b0;
        bus.res_rdy = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        bus.in_vld  = 1'b0;
        bus.res_rdy = 1'b0;
        tick();
        check("rst_in_rdy", 32'(bus.in_rdy), 32'd0);
        check("rst_op_vld", 32'(bus.op_vld), 32'd0);
        check("rst_operand_a", bus.operand_a, 32'd0);
        check("rst_sb_vld", 32'(bus.sb_vld), 32'd0);
        check("rst_sb_res", bus.sb_res, 32'd0);
        check("rst_err_unexp", 32'(bus.err_unexp), 32'd0);
        check("rst_err_tmo", 32'(bus.err_tmo), 32'd0);
        check("pending_op", 32'(exp_op_q.size()), 32'd0);
        check("pending_sb", 32'(exp_sb_q.size()), 32'd0);
        tick();
        rst = 1'b0;
        mdl_q.delete();
        exp_op_q.delete();
        exp_sb_q.delete();
        mdl_err = 1'b0;
        #1;
        check("post_rst_in_rdy", 32'(bus.in_rdy), 32'd1);
    endtask

    // Monitor: every op_vld / sb_vld must match the head of its queue.
    always @(negedge clk) begin
        logic [95:0]  eo;
        logic [127:0] es;
        if (bus.op_vld) begin
            n_op_seen++;
            $display("op  a=%h b=%h c=%h", bus.operand_a, bus.operand_b, bus.operand_c);
            if (exp_op_q.size() == 0) begin
                check("op_unexpected", 32'd1, 32'd0);
            end else begin
                eo = exp_op_q.pop_front();
                check("operand_a", bus.operand_a, eo[95:64]);
                check("operand_b", bus.operand_b, eo[63:32]);
                check("operand_c", bus.operand_c, eo[31:0]);
            end
        end
        if (bus.sb_vld) begin
            n_sb_seen++;
            $display("sb  a=%h b=%h c=%h res=%h", bus.sb_a, bus.sb_b, bus.sb_c, bus.sb_res);
            if (exp_sb_q.size() == 0) begin
                check("sb_unexpected", 32'd1, 32'd0);
            end else begin
                es = exp_sb_q.pop_front();
                check("sb_a", bus.sb_a, es[127:96]);
                check("sb_b", bus.sb_b, es[95:64]);
                check("sb_c", bus.sb_c, es[63:32]);
                check("sb_res", bus.sb_res, es[31:0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int op_base;
        int sb_base;
        mdl_err     = 1'b0;
        rst         = 1'b1;
        bus.in_vld  = 1'b0;
        bus.in_a    = '0;
        bus.in_b    = '0;
        bus.in_c    = '0;
        bus.res_rdy = 1'b0;
        bus.res     = '0;
        do_reset();

        // single op: accept at T, result at T+5, scoreboard at T+6
        drive(1'b1, 32'h3F800000, 32'h40000000, 32'h0, 1'b0, 32'h0);
        check("single_op_vld", 32'(bus.op_vld), 32'd1);
        check("single_operand_a", bus.operand_a, 32'h3F800000);
        idle(4);
        check("single_op_vld_low", 32'(bus.op_vld), 32'd0);
        check("single_operand_hold", bus.operand_b, 32'h40000000);
        drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 32'h40000000);
        check("single_sb_vld", 32'(bus.sb_vld), 32'd1);
        check("single_sb_res", bus.sb_res, 32'h40000000);
        check("single_state_idle", 32'(dut.state_q), 32'd0);

        // fill to MAX_OUT, pop one, then the 9th accept succeeds
        for (int i = 0; i < 8; i++)
            drive(1'b1, 32'h100 + 32'(i), 32'h200 + 32'(i), 32'h300 + 32'(i), 1'b0, 32'h0);
        check("full_in_rdy", 32'(bus.in_rdy), 32'd0);
        check("full_state", 32'(dut.state_q), 32'd2);
        drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 32'hA000);
        check("after_pop_in_rdy", 32'(bus.in_rdy), 32'd1);
        drive(1'b1, 32'h108, 32'h208, 32'h308, 1'b0, 32'h0);
        check("ninth_op_vld", 32'(bus.op_vld), 32'd1);
        for (int i = 1; i <= 8; i++)
            drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 32'hA000 + 32'(i));
        check("drained_state", 32'(dut.state_q), 32'd0);

        // ordering: a=1..4, results returned on consecutive cycles
        for (int i = 1; i <= 4; i++)
            drive(1'b1, 32'(i), 32'h0, 32'h0, 1'b0, 32'h0);
        for (int i = 1; i <= 4; i++) begin
            drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 32'hB000 + 32'(i));
            check("order_sb_a", bus.sb_a, 32'(i));
        end

        // simultaneous accept and pop leaves out_cnt unchanged
        drive(1'b1, 32'h5, 32'h0, 32'h0, 1'b0, 32'h0);
        check("simul_cnt_before", 32'(dut.out_cnt_q), 32'd1);
        drive(1'b1, 32'h6, 32'h0, 32'h0, 1'b1, 32'hC005);
        check("simul_cnt_after", 32'(dut.out_cnt_q), 32'd1);
        drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 32'hC006);
        idle(1);

        // unexpected result after reset
        do_reset();
        drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 32'hDEAD);
        check("unexp_err", 32'(bus.err_unexp), 32'd1);
        check("unexp_in_rdy", 32'(bus.in_rdy), 32'd0);
        check("unexp_sb_vld", 32'(bus.sb_vld), 32'd0);
        check("unexp_state", 32'(dut.state_q), 32'd3);
        do_reset();
        check("unexp_cleared", 32'(bus.err_unexp), 32'd0);

        // timeout: flag exactly 64 cycles after the accept
        drive(1'b1, 32'h77, 32'h0, 32'h0, 1'b0, 32'h0);   // now T+1
        for (int i = 0; i < 62; i++) tick();              // now T+63
        check("tmo_not_yet", 32'(bus.err_tmo), 32'd0);
        tick();                                           // now T+64
        check("tmo_set", 32'(bus.err_tmo), 32'd1);
        check("tmo_state", 32'(dut.state_q), 32'd3);
        mdl_err = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 32'h1234);
        check("tmo_no_sb", 32'(bus.sb_vld), 32'd0);
        check("tmo_unexp_held", 32'(bus.err_unexp), 32'd0);
        do_reset();

        // reset mid-flight: three ops outstanding, then reset drops them
        op_base = n_op_seen;
        sb_base = n_sb_seen;
        for (int i = 0; i < 3; i++)
            drive(1'b1, 32'h900 + 32'(i), 32'h1, 32'h2, 1'b0, 32'h0);
        idle(1);
`ifdef VFPU_ISSUE_STATS_EN
        check("stats_issue", issue_cnt, 32'(n_op_seen - op_base));
        check("stats_cmpl", cmpl_cnt, 32'(n_sb_seen - sb_base));
`endif
        do_reset();
`ifdef VFPU_ISSUE_STATS_EN
        check("stats_issue_rst", issue_cnt, 32'd0);
`endif
        drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 32'h5555);
        check("midflight_unexp", 32'(bus.err_unexp), 32'd1);
        check("midflight_no_sb", 32'(bus.sb_vld), 32'd0);
        idle(2);
        check("final_pending_op", 32'(exp_op_q.size()), 32'd0);
        check("final_pending_sb", 32'(exp_sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
